imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
Sequencer and arbiter that shares the single-ported 16 KB main memory between the instruction-fetch port and the data-memory port of the pipeline. It checks region and alignment for every access and issues one memory transaction at a time with a req/ack handshake. It returns read data or a trap with a cause code, and bounds data-port priority so fetch cannot starve. It sits between the IF/MEM pipeline stages and the main memory array.

Parameters:
MAX_DM_STREAK, 4, consecutive DM grants allowed while if_req is pending before IF is forced in.
TIMEOUT, 16, BUSY cycles without mem_ack before the access is aborted with a trap.
IM_BASE, 2048, first byte of the instruction region.
DM_BASE, 6144, first byte of the data region (stack+heap); the instruction region ends at DM_BASE-1.
MEM_BYTES, 16384, total memory size; the data region ends at MEM_BYTES-1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request.
if_addr  in  64  fetch byte address (pc).
if_rdata  out  32  fetched instruction.
if_valid  out  1  one-cycle pulse: if_rdata valid.
if_trap  out  1  one-cycle pulse: fetch trapped.
dm_req  in  1  data request.
dm_we  in  1  1=store, 0=load.
dm_addr  in  64  data byte address.
dm_wdata  in  32  store data.
dm_rdata  out  32  load data.
dm_valid  out  1  one-cycle pulse: load/store done.
dm_trap  out  1  one-cycle pulse: data access trapped.
trap_cause  out  2  00 none, 01 region, 10 misaligned, 11 timeout; valid with either trap pulse.
mem_en  out  1  memory request, held until mem_ack.
mem_we  out  1  memory write enable.
mem_addr  out  12  word index = addr[13:2].
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data, valid with mem_ack.
mem_ack  in  1  memory completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; streak and timeout counters 0. Reset during BUSY drops mem_en immediately and produces no response.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE arbitration:
  - DM wins if dm_req=1, unless if_req=1 and streak==MAX_DM_STREAK, in which case IF wins.
  - IF wins if only if_req=1.
  - A request seen high in IDLE is always a new request.
- Streak counter: +1 on each DM grant while if_req=1; cleared on an IF grant, or on a DM grant with if_req=0.
- Legality check on the granted request:
  - misaligned if addr[1:0]!=0 (cause 10); checked before region.
  - IF region: IM_BASE <= addr < DM_BASE, otherwise cause 01.
  - DM region: DM_BASE <= addr < MEM_BYTES, for loads and stores, otherwise cause 01.
  - Upper address bits are compared at the full 64-bit width.
- Illegal request: no mem_en; go to RESP with the requester's trap=1 and trap_cause set.
- Legal request: next cycle mem_en=1; mem_we=dm_we for DM, 0 for IF; mem_addr=addr[13:2]; mem_wdata=dm_wdata for stores. Enter BUSY.
- BUSY:
  - mem_en, mem_we, mem_addr and mem_wdata are held stable.
  - mem_ack is honoured only while mem_en=1. On ack, capture mem_rdata into the granted requester's rdata (stores leave dm_rdata unchanged), drop mem_en, go to RESP with valid=1.
  - Timeout counter increments each BUSY cycle without ack. On reaching TIMEOUT, drop mem_en and go to RESP with trap=1, cause 11.
- RESP: exactly one cycle. The granted port's valid or trap is 1; trap_cause is set (00 on valid). Then return to IDLE. if_rdata/dm_rdata hold their last value between responses.
- Latency:
  - grant at cycle N, mem_en at N+1.
  - ack at M≥N+1 gives valid at M+1.
  - minimum request-to-valid is 2 cycles when ack comes in the first mem_en cycle.
  - trap response arrives at N+1.
  - next grant is evaluated at M+2.
- Requester rules: hold req/addr/we/wdata stable until its valid or trap. Keeping req high after the response cycle issues a new request, so back-to-back requests are allowed. A requester that drops req mid-transaction still receives its response pulse.
- Simultaneous if_req and dm_req: the loser waits with no response; its request stays pending.

Test Plan:
- Fetch if_addr=2048, ack one cycle after mem_en with mem_rdata=0x00500093 -> mem_addr=512, mem_we=0; if_valid pulse with if_rdata=0x00500093 at ack+1.
- Store dm_addr=6148, wdata=0xDEADBEEF, then load from 6148 through a memory model -> mem_we=1, mem_addr=1537; load returns dm_rdata=0xDEADBEEF.
- if_addr=6144 -> if_trap, cause 01. dm_addr=2048 -> dm_trap, cause 01. dm_addr=6146 -> dm_trap, cause 10. None of these assert mem_en.
- if_req and dm_req held high continuously with a 1-cycle ack -> grant order is DM,DM,DM,DM,IF,DM,DM,DM,DM,IF (MAX_DM_STREAK=4).
- mem_ack never asserted -> mem_en high exactly 16 cycles, then trap with cause 11; the next request is served normally.
- rst_n pulled low mid-BUSY -> mem_en=0 immediately; no valid or trap pulse; after release state is IDLE and counters are 0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch port, data port and main-memory port around imem_port_arbiter.
// Requests hold until their one-cycle valid/trap pulse; mem_en holds until mem_ack.
interface imem_port_arbiter_if;
  // Handshake: a requester raises *_req with stable address/data and keeps it
  // until it sees its *_valid or *_trap pulse. The arbiter raises mem_en with
  // stable mem_we/mem_addr/mem_wdata and keeps it until mem_ack is sampled high.
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_trap;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_trap;

  logic [1:0]  trap_cause;

  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_trap, dm_rdata, dm_valid, dm_trap, trap_cause,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_trap, dm_rdata, dm_valid, dm_trap, trap_cause,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access:
// arbitration with bounded data priority, legality checks, one transaction at a time.
module imem_port_arbiter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 16,
  parameter int IM_BASE       = 2048,
  parameter int DM_BASE       = 6144,
  parameter int MEM_BYTES     = 16384,
  localparam int SW = $clog2(MAX_DM_STREAK + 1),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_port_arbiter_if.slave bus,
  output logic [1:0]         dbg_state_o,
  output logic [SW-1:0]      dbg_streak_o,
  output logic [TW-1:0]      dbg_tmo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_REGION = 2'b01;
  localparam logic [1:0] CAUSE_MISAL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO    = 2'b11;

  localparam logic [63:0]   IM_LO      = 64'(IM_BASE);
  localparam logic [63:0]   DM_LO      = 64'(DM_BASE);
  localparam logic [63:0]   MEM_TOP    = 64'(MEM_BYTES);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          gnt_dm_q, gnt_dm_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [11:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          if_trap_q, if_trap_d;
  logic          dm_valid_q, dm_valid_d;
  logic          dm_trap_q, dm_trap_d;
  logic [1:0]    cause_q, cause_d;

  // Legality is judged on the full 64-bit address so aliases above 16 KB trap.
  logic if_misal, if_oor, dm_misal, dm_oor;
  assign if_misal = (bus.if_addr[1:0] != 2'b00);
  assign if_oor   = (bus.if_addr < IM_LO) || (bus.if_addr >= DM_LO);
  assign dm_misal = (bus.dm_addr[1:0] != 2'b00);
  assign dm_oor   = (bus.dm_addr < DM_LO) || (bus.dm_addr >= MEM_TOP);

  logic        pick_dm;
  logic [11:0] gnt_word;
  logic [1:0]  gnt_cause;

  always_comb begin
    state_d     = state_q;
    gnt_dm_d    = gnt_dm_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    if_trap_d   = 1'b0;
    dm_valid_d  = 1'b0;
    dm_trap_d   = 1'b0;
    cause_d     = CAUSE_NONE;

    // Data side wins unless fetch has already waited through a full streak.
    pick_dm  = bus.dm_req && !(bus.if_req && (streak_q == STREAK_MAX));
    gnt_word = pick_dm ? bus.dm_addr[13:2] : bus.if_addr[13:2];
    if (pick_dm ? dm_misal : if_misal) begin
      gnt_cause = CAUSE_MISAL;
    end else if (pick_dm ? dm_oor : if_oor) begin
      gnt_cause = CAUSE_REGION;
    end else begin
      gnt_cause = CAUSE_NONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          gnt_dm_d = pick_dm;
          streak_d = (pick_dm && bus.if_req) ? streak_q + 1'b1 : '0;
          if (gnt_cause != CAUSE_NONE) begin
            state_d   = S_RESP;
            if_trap_d = !pick_dm;
            dm_trap_d = pick_dm;
            cause_d   = gnt_cause;
          end else begin
            state_d     = S_BUSY;
            mem_en_d    = 1'b1;
            mem_we_d    = pick_dm && bus.dm_we;
            mem_addr_d  = gnt_word;
            mem_wdata_d = (pick_dm && bus.dm_we) ? bus.dm_wdata : 32'h0;
            tmo_d       = '0;
          end
        end
      end

      S_BUSY: begin
        if (mem_en_q && bus.mem_ack) begin
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          tmo_d    = '0;
          if (gnt_dm_q) begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_RESP;
          mem_en_d  = 1'b0;
          mem_we_d  = 1'b0;
          tmo_d     = '0;
          if_trap_d = !gnt_dm_q;
          dm_trap_d = gnt_dm_q;
          cause_d   = CAUSE_TMO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_dm_q    <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      if_trap_q   <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_trap_q   <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      gnt_dm_q    <= gnt_dm_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      if_trap_q   <= if_trap_d;
      dm_valid_q  <= dm_valid_d;
      dm_trap_q   <= dm_trap_d;
      cause_q     <= cause_d;
    end
  end

  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_trap    = if_trap_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.dm_valid   = dm_valid_q;
  assign bus.dm_trap    = dm_trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  assign dbg_state_o  = state_q;
  assign dbg_streak_o = streak_q;
  assign dbg_tmo_o    = tmo_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: request drivers, a memory responder and a
// response scoreboard fed at drive time.
module tb_imem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [2:0] dbg_streak;
  logic [4:0] dbg_tmo;

  imem_port_arbiter_if bus();

  imem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_streak_o (dbg_streak),
    .dbg_tmo_o    (dbg_tmo)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [35:0] exp_q[$];      // {is_dm, is_trap, cause, data}
  logic [44:0] exp_mem_q[$];  // {we, word, wdata}

  logic [31:0] ref_mem   [4096];
  logic [31:0] mem_model [4096];
  logic [31:0] model_dm_rdata;

  int   ack_delay;
  logic ack_on;
  int   en_cycles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] pack_resp(input logic is_dm, input logic is_trap,
                                            input logic [1:0] cause, input logic [31:0] data);
    return {is_dm, is_trap, cause, data};
  endfunction

  function automatic logic [1:0] exp_cause(input logic is_dm, input logic [63:0] a);
    if (a[1:0] != 2'b00) return 2'b10;
    if (is_dm) return (a >= 64'd6144 && a < 64'd16384) ? 2'b00 : 2'b01;
    return (a >= 64'd2048 && a < 64'd6144) ? 2'b00 : 2'b01;
  endfunction

  function automatic logic any_pulse();
    return bus.if_valid | bus.if_trap | bus.dm_valid | bus.dm_trap;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int wait_cnt;
    logic [44:0] tx;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_en) begin
        en_cycles++;
        if (ack_on) begin
          if (wait_cnt >= ack_delay) begin
            wait_cnt = 0;
            if (exp_mem_q.size() == 0) begin
              check("mem_unexpected", 64'(bus.mem_en), 64'd0);
            end else begin
              tx = exp_mem_q.pop_front();
              check("mem_tx", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(tx));
            end
            if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
            else            bus.mem_rdata = mem_model[bus.mem_addr];
            bus.mem_ack = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    int          n_p;
    logic        is_dm, is_trap;
    logic [31:0] data;
    logic [35:0] obs, e;
    forever begin
      @(negedge clk);
      n_p = int'(bus.if_valid) + int'(bus.if_trap) + int'(bus.dm_valid) + int'(bus.dm_trap);
      if (n_p != 0) begin
        if (n_p > 1) check("resp_multi", 64'(n_p), 64'd1);
        is_dm   = bus.dm_valid | bus.dm_trap;
        is_trap = bus.if_trap | bus.dm_trap;
        data    = is_trap ? 32'h0 : (is_dm ? bus.dm_rdata : bus.if_rdata);
        obs     = pack_resp(is_dm, is_trap, bus.trap_cause, data);
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(n_p), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp", 64'(obs), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input string tag);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (any_pulse()) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_resp_wait"}, 64'(got), 64'd1);
  endtask

  task automatic if_access(input logic [63:0] a);
    logic [1:0]  c;
    logic [11:0] w;
    c = exp_cause(1'b0, a);
    w = a[13:2];
    if (c != 2'b00) begin
      exp_q.push_back(pack_resp(1'b0, 1'b1, c, 32'h0));
    end else begin
      exp_mem_q.push_back({1'b0, w, 32'h0});
      exp_q.push_back(pack_resp(1'b0, 1'b0, 2'b00, ref_mem[w]));
    end
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    wait_resp("if");
    bus.if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [63:0] a, input logic [31:0] wd);
    logic [1:0]  c;
    logic [11:0] w;
    c = exp_cause(1'b1, a);
    w = a[13:2];
    if (c != 2'b00) begin
      exp_q.push_back(pack_resp(1'b1, 1'b1, c, 32'h0));
    end else begin
      exp_mem_q.push_back({we, w, we ? wd : 32'h0});
      if (we) ref_mem[w] = wd;
      else    model_dm_rdata = ref_mem[w];
      exp_q.push_back(pack_resp(1'b1, 1'b0, 2'b00, model_dm_rdata));
    end
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = wd;
    wait_resp("dm");
    bus.dm_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] a;
    int          n;

    for (int i = 0; i < 4096; i++) begin
      ref_mem[i]   = (32'(i) * 32'h01000193) ^ 32'hC0FFEE00;
      mem_model[i] = ref_mem[i];
    end
    ref_mem[512]   = 32'h00500093;
    mem_model[512] = 32'h00500093;
    model_dm_rdata = 32'h0;
    ack_delay      = 1;
    ack_on         = 1'b1;
    en_cycles      = 0;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_en",   64'(bus.mem_en),     64'd0);
    check("rst_if_valid", 64'(bus.if_valid),   64'd0);
    check("rst_dm_valid", 64'(bus.dm_valid),   64'd0);
    check("rst_traps",    64'({bus.if_trap, bus.dm_trap}), 64'd0);
    check("rst_cause",    64'(bus.trap_cause), 64'd0);
    check("rst_rdata",    64'({bus.if_rdata, bus.dm_rdata}), 64'd0);
    check("rst_state",    64'(dbg_state),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch, then store/load round trip through the memory model.
    if_access(64'd2048);
    dm_access(1'b1, 64'd6148, 32'hDEADBEEF);
    dm_access(1'b0, 64'd6148, 32'h0);

    // Illegal accesses and region boundaries.
    if_access(64'd6144);
    dm_access(1'b0, 64'd2048, 32'h0);
    dm_access(1'b0, 64'd6146, 32'h0);
    if_access(64'd2044);
    if_access(64'd6140);
    if_access(64'd2050);
    dm_access(1'b0, 64'd16380, 32'h0);
    dm_access(1'b0, 64'd16384, 32'h0);
    dm_access(1'b1, 64'd6140, 32'h12345678);
    dm_access(1'b0, 64'd1, 32'h0);
    if_access(64'h0000_0001_0000_0800);
    dm_access(1'b0, 64'h8000_0000_0000_1800, 32'h0);
    check("sb_drain_directed", 64'(exp_q.size()), 64'd0);

    // Random mix with random memory latency.
    for (int k = 0; k < 16; k++) begin
      ack_delay = $urandom_range(0, 3);
      a = 64'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) if_access(a);
      else dm_access(1'($urandom_range(0, 1)), a, $urandom);
    end

    // Both ports requesting continuously: four data grants then one fetch.
    ack_delay = 0;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) begin
        exp_mem_q.push_back({1'b0, 12'd513, 32'h0});
        exp_q.push_back(pack_resp(1'b0, 1'b0, 2'b00, ref_mem[513]));
      end else begin
        exp_mem_q.push_back({1'b0, 12'd1540, 32'h0});
        model_dm_rdata = ref_mem[1540];
        exp_q.push_back(pack_resp(1'b1, 1'b0, 2'b00, model_dm_rdata));
      end
    end
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 64'd2052;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'd6160;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (any_pulse()) n++;
      if (n == 10) break;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    check("arb_count", 64'(n), 64'd10);

    // Memory never acknowledges: abort after 16 cycles, then recover.
    ack_on    = 1'b0;
    en_cycles = 0;
    exp_q.push_back(pack_resp(1'b1, 1'b1, 2'b11, 32'h0));
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'd6152;
    wait_resp("tmo");
    bus.dm_req = 1'b0;
    check("tmo_en_cycles", 64'(en_cycles), 64'd16);
    ack_on    = 1'b1;
    ack_delay = 1;
    dm_access(1'b0, 64'd6152, 32'h0);

    // Reset in the middle of a transaction.
    ack_on = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 64'd2048;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'd6144;
    repeat (4) @(negedge clk);
    check("rst_pre_en",     64'(bus.mem_en), 64'd1);
    check("rst_pre_streak", 64'(dbg_streak), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_en", 64'(bus.mem_en), 64'd0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_post_state",  64'(dbg_state),  64'd0);
    check("rst_post_streak", 64'(dbg_streak), 64'd0);
    check("rst_post_tmo",    64'(dbg_tmo),    64'd0);
    check("rst_post_rdata",  64'(bus.dm_rdata), 64'd0);
    ack_on         = 1'b1;
    model_dm_rdata = 32'h0;
    if_access(64'd2048);
    dm_access(1'b1, 64'd6148, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    check("sb_resp_empty", 64'(exp_q.size()),     64'd0);
    check("sb_mem_empty",  64'(exp_mem_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
